// File: rtl/ddr_frame_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ddr_frame_reader: credit-gated DDR3 burst reads of one frame, buffered into  |
// | a show-ahead FIFO and streamed out as valid/ready words.                     |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module ddr_frame_reader #(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 128,
  parameter int BURST_BEATS  = 8,
  parameter int ADDR_STEP    = 64,
  parameter int FRAME_BURSTS = 4800,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_calib_complete,
  input  logic                  frame_start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic [2:0]            cmd_o,
  output logic                  cmd_en_o,
  input  logic                  cmd_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_data_valid_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = CW + 1;
  localparam int BW = $clog2(FRAME_BURSTS + 1);

  localparam logic [CW-1:0]         c_burst_beats = CW'(BURST_BEATS);
  localparam logic [CW-1:0]         c_fifo_depth  = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_addr_step   = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [BW-1:0]         c_last_burst  = BW'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BW-1:0]         r_burst_cnt;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  r_frame_done;
  logic                  r_err;

  logic          w_full;
  logic          w_pop;
  logic          w_beat_ok;
  logic          w_beat_bad;
  logic          w_credit;
  logic          w_cmd_en;
  logic          w_accept;
  logic [CW-1:0] w_out_next;

  assign w_full = (r_count == c_fifo_depth);
  assign w_pop  = (r_count != '0) & m_ready_i;

  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign w_beat_ok  = rd_data_valid_i & (r_outstanding != '0) & (~w_full | w_pop);
  assign w_beat_bad = rd_data_valid_i & ~w_beat_ok;

  // Reserve room for a whole burst before asking for it, so returning beats always fit.
  assign w_credit = ({1'b0, r_count} + {1'b0, r_outstanding} + {1'b0, c_burst_beats})
                    <= {1'b0, c_fifo_depth};
  assign w_cmd_en = (r_state == ST_ISSUE) & init_calib_complete & w_credit;
  assign w_accept = w_cmd_en & cmd_ready_i;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept)  w_out_next = w_out_next + c_burst_beats;
    if (w_beat_ok) w_out_next = w_out_next - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_burst_cnt   <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_outstanding <= w_out_next;
      if (w_beat_bad) r_err <= 1'b1;
      if (w_beat_ok)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_beat_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (frame_start_i && init_calib_complete) begin
            r_addr      <= base_addr_i;
            r_burst_cnt <= '0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_accept) begin
            r_addr      <= r_addr + c_addr_step;
            r_burst_cnt <= r_burst_cnt + BW'(1);
            if (r_burst_cnt == c_last_burst) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_next == '0) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_beat_ok) r_mem[r_wr_ptr] <= rd_data_i;
  end

  assign cmd_o        = 3'b001;
  assign cmd_en_o     = w_cmd_en;
  assign addr_o       = r_addr;
  // Gate the head so the stream bus reads zero whenever nothing is buffered.
  assign m_data_o     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign m_valid_o    = (r_count != '0);
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_frame_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ddr_frame_reader: directed frame vectors plus hand sequences for         |
// | back-pressure, ignored starts and mid-frame reset.                          |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_ddr_frame_reader;

  localparam int AW = 29;
  localparam int DW = 32;
  localparam int BB = 8;
  localparam int FD = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          init_calib_complete;
  logic          frame_start_i;
  logic [AW-1:0] base_addr_i;
  logic [2:0]    cmd_o;
  logic          cmd_en_o;
  logic          cmd_ready_i;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] rd_data_i = '0;
  logic          rd_data_valid_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b1;
  logic          busy_o;
  logic          frame_done_o;
  logic          err_o;

  ddr_frame_reader #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BURST_BEATS (BB),
    .ADDR_STEP   (64),
    .FRAME_BURSTS(4),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .init_calib_complete(init_calib_complete),
    .frame_start_i      (frame_start_i),
    .base_addr_i        (base_addr_i),
    .cmd_o              (cmd_o),
    .cmd_en_o           (cmd_en_o),
    .cmd_ready_i        (cmd_ready_i),
    .addr_o             (addr_o),
    .rd_data_i          (rd_data_i),
    .rd_data_valid_i    (rd_data_valid_i),
    .m_data_o           (m_data_o),
    .m_valid_o          (m_valid_o),
    .m_ready_i          (m_ready_i),
    .busy_o             (busy_o),
    .frame_done_o       (frame_done_o),
    .err_o              (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0]      base;
    logic [3:0]         stall;
    logic [1:0]         rdy_mode;
    logic [3:0][AW-1:0] exp_addr;
  } vec_t;

  vec_t          vecs [4];
  int            n_vec = 0;
  int            n_err = 0;
  int            pend = 0;
  int            beat_seq = 0;
  int            exp_word = 0;
  int            words = 0;
  int            fd_cnt = 0;
  bit            ret_en = 1'b0;
  int            rdy_mode = 0;
  logic [AW-1:0] acc_q [$];

  // Observe at the falling edge: values here are what the next rising edge acts on.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (cmd_en_o && cmd_ready_i) begin
        acc_q.push_back(addr_o);
        pend += BB;
      end
      if (frame_done_o) fd_cnt++;
      if (m_valid_o && m_ready_i) begin
        n_vec++;
        if (m_data_o !== DW'(exp_word)) begin
          n_err++;
          $display("FAIL stream_word: got 0x%0h expected 0x%0h", m_data_o, exp_word);
        end
        exp_word++;
        words++;
      end
    end
  end

  // Memory model returns one beat per cycle for every accepted command.
  always @(posedge clk_i) begin
    #2;
    if (ret_en && pend > 0) begin
      rd_data_valid_i = 1'b1;
      rd_data_i       = DW'(beat_seq);
      beat_seq++;
      pend--;
    end else begin
      rd_data_valid_i = 1'b0;
    end
    case (rdy_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = ~m_ready_i;
      default: m_ready_i = 1'b0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] b);
    frame_start_i = 1'b1;
    base_addr_i   = b;
    tick(1);
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int fd0, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (fd_cnt != fd0) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_done_timeout: got no pulse within %0d cycles, required one", budget);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && m_valid_o; i++) tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int stall_n;
    bit ok;

    vecs[0] = '{base: 29'h100, stall: 4'd0, rdy_mode: 2'd0,
                exp_addr: {29'h1C0, 29'h180, 29'h140, 29'h100}};
    vecs[1] = '{base: 29'h1FFF_FFC0, stall: 4'd0, rdy_mode: 2'd0,
                exp_addr: {29'h80, 29'h40, 29'h0, 29'h1FFF_FFC0}};
    vecs[2] = '{base: 29'hABC0, stall: 4'd5, rdy_mode: 2'd0,
                exp_addr: {29'hAC80, 29'hAC40, 29'hAC00, 29'hABC0}};
    vecs[3] = '{base: 29'h2000, stall: 4'd0, rdy_mode: 2'd1,
                exp_addr: {29'h20C0, 29'h2080, 29'h2040, 29'h2000}};

    rst_i               = 1'b1;
    init_calib_complete = 1'b1;
    frame_start_i       = 1'b0;
    base_addr_i         = '0;
    cmd_ready_i         = 1'b1;
    tick(3);
    @(negedge clk_i);
    check("rst_cmd", cmd_o, 3'b001);
    check("rst_cmd_en", cmd_en_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_err", err_o, 0);
    tick(1);
    rst_i = 1'b0;
    tick(1);

    for (int v = 0; v < 4; v++) begin
      acc_q.delete();
      words    = 0;
      fd0      = fd_cnt;
      rdy_mode = int'(vecs[v].rdy_mode);
      ret_en   = 1'b1;
      stall_n  = int'(vecs[v].stall);
      if (stall_n != 0) cmd_ready_i = 1'b0;
      start_frame(vecs[v].base);
      check("busy_start", busy_o, 1);
      if (stall_n != 0) begin
        for (int c = 0; c < stall_n; c++) begin
          @(negedge clk_i);
          check("stall_cmd_en", cmd_en_o, 1);
          check("stall_addr", addr_o, vecs[v].exp_addr[0]);
        end
        tick(1);
        cmd_ready_i = 1'b1;
      end
      wait_done(fd0, 400);
      rdy_mode = 0;
      drain(100);
      tick(2);
      check("accept_count", acc_q.size(), 4);
      for (int k = 0; k < 4; k++)
        if (k < acc_q.size()) check("cmd_addr", acc_q[k], vecs[v].exp_addr[k]);
      check("word_count", words, 32);
      check("frame_done_pulses", fd_cnt - fd0, 1);
      check("frame_err", err_o, 0);
      check("busy_end", busy_o, 0);
    end

    // Consumer stalled: credit must cap issue at two bursts of a 16-entry FIFO.
    acc_q.delete();
    words    = 0;
    fd0      = fd_cnt;
    rdy_mode = 2;
    ret_en   = 1'b1;
    start_frame(29'h3000);
    tick(60);
    check("bp_accepts", acc_q.size(), 2);
    check("bp_cmd_en", cmd_en_o, 0);
    check("bp_valid", m_valid_o, 1);
    check("bp_busy", busy_o, 1);
    start_frame(29'h0555_5540);
    tick(10);
    check("busy_start_ignored", acc_q.size(), 2);
    check("busy_still", busy_o, 1);
    rdy_mode = 0;
    wait_done(fd0, 400);
    drain(100);
    tick(2);
    check("bp_accept_total", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      check("bp_addr0", acc_q[0], 29'h3000);
      check("bp_addr3", acc_q[3], 29'h30C0);
    end
    check("bp_words", words, 32);
    check("bp_err", err_o, 0);
    check("bp_done", fd_cnt - fd0, 1);

    // Start while the controller is uncalibrated must leave the block idle.
    acc_q.delete();
    init_calib_complete = 1'b0;
    start_frame(29'h7000);
    tick(5);
    check("nocal_busy", busy_o, 0);
    check("nocal_cmd_en", cmd_en_o, 0);
    init_calib_complete = 1'b1;
    tick(3);
    check("nocal_busy_after", busy_o, 0);
    check("nocal_accepts", acc_q.size(), 0);

    // Reset with two bursts in flight; their late beats must be flagged, not stored.
    acc_q.delete();
    fd0      = fd_cnt;
    ret_en   = 1'b0;
    rdy_mode = 0;
    start_frame(29'h4000);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick(1);
      if (acc_q.size() >= 2) ok = 1'b1;
    end
    tick(5);
    check("rst6_accepts", acc_q.size(), 2);
    check("rst6_cmd_en", cmd_en_o, 0);
    check("rst6_err_before", err_o, 0);
    rst_i = 1'b1;
    tick(2);
    rst_i  = 1'b0;
    ret_en = 1'b1;
    for (int i = 0; i < 100 && pend > 0; i++) tick(1);
    tick(3);
    check("rst6_pending_returned", pend, 0);
    check("rst6_m_valid", m_valid_o, 0);
    check("rst6_err", err_o, 1);
    check("rst6_busy", busy_o, 0);
    check("rst6_no_done", fd_cnt - fd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
